data_mem_io: RTL

Data-side responder for the single-cycle cpu data port (dataAddr/writeData/we in, readData out). Decodes each access to a word-addressed data RAM or a small MMIO register set: LED latch, free-running cycle counter, and a byte-wide TX FIFO with a valid/ready drain port toward a future UART. Reads are combinational (same-cycle, as the single-cycle core requires); all state updates occur on posedge clk.

---
 rtl/data_mem_io.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/data_mem_io.sv
// Data-side responder for the single-cycle core: word-addressed RAM plus a small
// MMIO block (LED latch, free-running cycle counter, byte-wide TX FIFO).
// Reads are combinational; all state changes on posedge clk with synchronous reset.
module data_mem_io #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        we,
  output logic [31:0] read_data,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fault
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Storage (not reset)
  logic [31:0] mem [RAM_WORDS];
  logic [7:0]  fifo_q [TX_DEPTH];

  // Registered state
  logic [7:0]    leds_q;
  logic [31:0]   cycle_q, cycle_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fault_q;

  // Address decode; addr[1:0] only matters for the misaligned-store check
  logic          ram_hit, mmio_hit;
  logic [5:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          sel_led, sel_cyc, sel_txd, sel_sts;
  logic          aligned, wr_ok, misaligned;

  assign ram_hit    = (addr[31:AW+2] == '0);
  assign ram_idx    = addr[AW+1:2];
  assign mmio_hit   = (addr[31:8] == MMIO_BASE[31:8]);
  assign reg_sel    = addr[7:2];
  assign sel_led    = mmio_hit && (reg_sel == 6'd0);
  assign sel_cyc    = mmio_hit && (reg_sel == 6'd1);
  assign sel_txd    = mmio_hit && (reg_sel == 6'd2);
  assign sel_sts    = mmio_hit && (reg_sel == 6'd3);
  assign aligned    = (addr[1:0] == 2'b00);
  assign wr_ok      = we && aligned;
  assign misaligned = we && !aligned;

  // FIFO handshake
  logic empty, full, pop, push_req, do_push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(TX_DEPTH));
  assign pop      = !empty && tx_ready;
  assign push_req = wr_ok && sel_txd;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push  = push_req && (!full || pop);

  // Next-state for counter, FIFO pointers/count and overflow flag
  always_comb begin
    cycle_d    = cycle_q + 32'd1;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_ok && sel_cyc) begin
      cycle_d = write_data;
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    if (do_push) begin
      wr_d = wr_q + PW'(1);
    end
    if (do_push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && pop) begin
      count_d = count_q - CW'(1);
    end
    if (wr_ok && sel_sts && write_data[2]) begin
      overflow_d = 1'b0;
    end
    // Set has priority over a same-cycle clear
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      leds_q     <= 8'h00;
      cycle_q    <= 32'd0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (wr_ok && sel_led) begin
        leds_q <= write_data[7:0];
      end
      cycle_q    <= cycle_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (misaligned) begin
        fault_q <= 1'b1;
      end
    end
  end

  // RAM write port; suppressed during reset so reset wins over a same-cycle store
  always_ff @(posedge clk) begin
    if (n_reset && wr_ok && ram_hit) begin
      mem[ram_idx] <= write_data;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (n_reset && do_push) begin
      fifo_q[wr_q] <= write_data[7:0];
    end
  end

  // Combinational load data; unmapped addresses read as zero
  always_comb begin
    read_data = 32'd0;
    if (ram_hit) begin
      read_data = mem[ram_idx];
    end else if (sel_led) begin
      read_data = {24'd0, leds_q};
    end else if (sel_cyc) begin
      read_data = cycle_q;
    end else if (sel_sts) begin
      read_data = {29'd0, overflow_q, full, empty};
    end
  end

  assign leds     = leds_q;
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_q];
  assign fault    = fault_q;

endmodule
